// File: rtl/hyst_fsm_array.sv
`default_nettype none
// ============================================================================
// hyst_fsm_array : NCH saturating up/down state chains with hysteresis output z
// Optional per-channel z-rise event counter under HYST_FSM_EVTCNT_EN.  Rev 1.0
// ============================================================================
module hyst_fsm_array #(
   parameter int NCH    = 4,
   parameter int DEPTH  = 5,
   parameter int ON_TH  = 3,
   parameter int OFF_TH = 1,
   parameter int SW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic [NCH-1:0]    x,
   input  logic [NCH-1:0]    en,
   input  logic [NCH-1:0]    clr,
   output logic [NCH*SW-1:0] state,
   output logic [NCH*SW-1:0] next_state,
   output logic [NCH-1:0]    z,
   output logic              any_z
`ifdef HYST_FSM_EVTCNT_EN
   ,
   output logic [NCH*8-1:0]  evt_cnt
`endif
);

   if (DEPTH < 2) begin : g_bad_depth
      $error("hyst_fsm_array: DEPTH must be >= 2");
   end
   if (ON_TH < 1 || ON_TH > DEPTH-1) begin : g_bad_on_th
      $error("hyst_fsm_array: ON_TH must be in 1..DEPTH-1");
   end
   if (OFF_TH < 0 || OFF_TH > ON_TH) begin : g_bad_off_th
      $error("hyst_fsm_array: OFF_TH must be in 0..ON_TH");
   end
   if (NCH < 1) begin : g_bad_nch
      $error("hyst_fsm_array: NCH must be >= 1");
   end

   logic [NCH-1:0][SW-1:0] state_q, state_d;
   logic [NCH-1:0]         z_q, z_d;

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      for (int i = 0; i < NCH; i++) begin
         // Encodings at or above DEPTH are unreachable; recover them to 0.
         if (clr[i] || int'(state_q[i]) >= DEPTH) begin
            state_d[i] = '0;
         end else if (en[i]) begin
            if (x[i]) begin
               if (int'(state_q[i]) < DEPTH-1) state_d[i] = state_q[i] + 1'b1;
            end else if (state_q[i] != '0) begin
               state_d[i] = state_q[i] - 1'b1;
            end
         end

         if (clr[i])                            z_d[i] = 1'b0;
         else if (int'(state_d[i]) >= ON_TH)    z_d[i] = 1'b1;
         else if (int'(state_d[i]) <  OFF_TH)   z_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
      end
   end

   assign state      = state_q;
   assign next_state = state_d;
   assign z          = z_q;
   assign any_z      = |z_q;

`ifdef HYST_FSM_EVTCNT_EN
   logic [NCH-1:0][7:0] evt_q, evt_d;
   logic [NCH-1:0]      z_prev_q;

   // Rise is detected on the registered z, so the count lags z by one cycle.
   always_comb begin
      evt_d = evt_q;
      for (int i = 0; i < NCH; i++) begin
         if (clr[i])                                         evt_d[i] = '0;
         else if (z_q[i] && !z_prev_q[i] && evt_q[i] != 8'hFF) evt_d[i] = evt_q[i] + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         evt_q    <= '0;
         z_prev_q <= '0;
      end else begin
         evt_q    <= evt_d;
         z_prev_q <= z_q;
      end
   end

   assign evt_cnt = evt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hyst_fsm_array.sv
`default_nettype none
// tb_hyst_fsm_array : directed self-checking bench for hyst_fsm_array at default parameters.
module tb_hyst_fsm_array;
   localparam int NCH = 4;
   localparam int SW  = 3;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [NCH-1:0]    x, en, clr;
   logic [NCH*SW-1:0] state, next_state;
   logic [NCH-1:0]    z;
   logic              any_z;
`ifdef HYST_FSM_EVTCNT_EN
   logic [NCH*8-1:0]  evt_cnt;
`endif

   int checks = 0;
   int errors = 0;

   hyst_fsm_array dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .x          (x),
      .en         (en),
      .clr        (clr),
      .state      (state),
      .next_state (next_state),
      .z          (z),
      .any_z      (any_z)
`ifdef HYST_FSM_EVTCNT_EN
      ,
      .evt_cnt    (evt_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned st(input int ch);
      return int'(state[ch*SW +: SW]);
   endfunction

   function automatic int unsigned nst(input int ch);
      return int'(next_state[ch*SW +: SW]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int exp_up_s  [6] = '{1, 2, 3, 4, 4, 4};
   int exp_up_z  [6] = '{0, 0, 1, 1, 1, 1};
   int exp_up_ns [6] = '{2, 3, 4, 4, 4, 4};
   int exp_dn_s  [5] = '{3, 2, 1, 0, 0};
   int exp_dn_z  [5] = '{1, 1, 1, 0, 0};

   initial begin
      aresetn = 1'b0;
      x = '0; en = '0; clr = '0;
      step();
      step();
      chk("rst_state", state, 0);
      chk("rst_z", z, 0);
      chk("rst_any_z", any_z, 0);
      chk("rst_next_state", next_state, 0);
      aresetn = 1'b1;
      step();
      chk("post_rel_hold", state, 0);

      // up ramp on ch0
      en = 4'b0001; x = 4'b0001;
      #1;
      chk("up_ns_lead", nst(0), 1);
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("up_s%0d", k), st(0), exp_up_s[k]);
         chk($sformatf("up_z%0d", k), z[0], exp_up_z[k]);
         chk($sformatf("up_ns%0d", k), nst(0), exp_up_ns[k]);
      end
      chk("up_any_z", any_z, 1);

      // async reset between edges
      #3;
      aresetn = 1'b0;
      #1;
      chk("async_state", state, 0);
      chk("async_z", z, 0);
      chk("async_any_z", any_z, 0);
      #1;
      aresetn = 1'b1;
      step();
      chk("after_rel_s", st(0), 1);
      step(); step(); step();
      chk("reramp_s", st(0), 4);
      chk("reramp_z", z[0], 1);

      // down ramp with hysteresis
      x = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("dn_s%0d", k), st(0), exp_dn_s[k]);
         chk($sformatf("dn_z%0d", k), z[0], exp_dn_z[k]);
         chk($sformatf("dn_anyz%0d", k), any_z, exp_dn_z[k]);
      end

      // hold and clear priority on ch1
      en = 4'b0010; x = 4'b0010;
      step(); step();
      chk("h_s_pre", st(1), 2);
      en = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("hold_s%0d", k), st(1), 2);
      end
      clr = 4'b0010; en = 4'b0010;
      #1;
      chk("clr_ns", nst(1), 0);
      step();
      chk("clr_s", st(1), 0);
      chk("clr_z", z[1], 0);
      clr = 4'b0000;

      // channel independence
      en = 4'b0110; x = 4'b0010;
      step(); step(); step(); step();
      chk("ind_ch1_s", st(1), 4);
      chk("ind_ch1_z", z[1], 1);
      chk("ind_ch2_s", st(2), 0);
      chk("ind_ch2_z", z[2], 0);
      chk("ind_ch0_s", st(0), 0);
      chk("ind_ch3_s", st(3), 0);
      chk("ind_any_z", any_z, 1);

      // clr overrides up-count while z is set
      clr = 4'b0010;
      step();
      chk("clr_hi_s", st(1), 0);
      chk("clr_hi_z", z[1], 0);
      chk("clr_hi_any", any_z, 0);
      clr = 4'b0000; en = 4'b0000; x = 4'b0000;

`ifdef HYST_FSM_EVTCNT_EN
      en = 4'b1000;
      for (int r = 0; r < 300; r++) begin
         x = 4'b1000;
         step(); step(); step();
         x = 4'b0000;
         if (r == 0) begin
            step();
            chk("evt_first", evt_cnt[3*8 +: 8], 1);
            step(); step();
         end else begin
            step(); step(); step();
         end
      end
      step();
      chk("evt_sat", evt_cnt[3*8 +: 8], 255);
      chk("evt_ch0", evt_cnt[0 +: 8], 1);
      clr = 4'b1000;
      step();
      clr = 4'b0000;
      chk("evt_clr", evt_cnt[3*8 +: 8], 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
